data_frame_packer: RTL and testbench

//  Consumer side of the compressed pixel stream. Takes the 14-bit averaged pixels
//  (compressed_data/data_valid, one pixel per 12 ad_fco_clk) and frames them: header word,
//  2 pixels per 32-bit word, trailer word. Output is a valid/ready word stream to the readout FIFO.

---
 rtl/beam_data_pkg.sv | 28 ++
 rtl/sync_word_fifo.sv | 64 ++++++
 rtl/data_frame_packer.sv | 169 ++++++++++++++++
 tb/tb_data_frame_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/beam_data_pkg.sv
// Shared constants, word layout and FSM encoding for the per-channel pixel frame packer.
package beam_data_pkg;

  localparam int unsigned PIXELS_PER_FRAME = 5184;
  localparam logic [15:0] HEADER_MAGIC     = 16'hAA55;
  localparam logic [7:0]  TRAILER_TAG      = 8'hEE;
  localparam int unsigned FIFO_DEPTH       = 4;

  localparam int unsigned PIX_W   = 14;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ENTRY_W = WORD_W + 1;  // tlast rides along as the top bit
  localparam int unsigned CNT_W   = 16;

  // Field offsets inside a 32-bit output word
  localparam int unsigned LO_PIX_LSB = 0;
  localparam int unsigned HI_PIX_LSB = 16;
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned ERR_BIT    = 16;
  localparam int unsigned TAG_LSB    = 24;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_HEADER  = 4'b0010,
    ST_PIXELS  = 4'b0100,
    ST_TRAILER = 4'b1000
  } state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock show-ahead FIFO: the head entry is presented on data_o whenever empty_o is low.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_word_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_word_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: storage array is deliberately not reset; the gated read below hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/data_frame_packer.sv
// Frames the compressed 14-bit pixel stream as header, packed pixel pairs and trailer,
// and buffers the resulting words for a valid/ready consumer.
module data_frame_packer import beam_data_pkg::*; #(
  parameter int unsigned PIXELS_PER_FRAME = beam_data_pkg::PIXELS_PER_FRAME,
  parameter logic [15:0] HEADER_MAGIC     = beam_data_pkg::HEADER_MAGIC,
  parameter logic [7:0]  TRAILER_TAG      = beam_data_pkg::TRAILER_TAG,
  parameter int unsigned FIFO_DEPTH       = beam_data_pkg::FIFO_DEPTH
) (
  input  logic              ad_fco_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              data_valid,
  input  logic [PIX_W-1:0]  compressed_data,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              overflow
);

  if (PIXELS_PER_FRAME < 2 || PIXELS_PER_FRAME > 65535 || (PIXELS_PER_FRAME % 2) != 0)
  begin : g_bad_ppf
    $error("data_frame_packer: PIXELS_PER_FRAME must be even and fit in 16 bits");
  end

  localparam logic [CNT_W-1:0] PIX_TARGET = PIXELS_PER_FRAME[CNT_W-1:0];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PIX_W-1:0]   pair_q, pair_d;
  logic               pend_valid_q, pend_valid_d;
  logic [WORD_W-1:0]  pend_word_q, pend_word_d;
  logic               frame_err_q, frame_err_d;
  logic               restart_q, restart_d;
  logic               overflow_q, overflow_d;

  logic               enq_valid, enq_last, capture;
  logic [WORD_W-1:0]  enq_word;
  logic [ENTRY_W-1:0] fifo_rd;
  logic               fifo_full, fifo_empty, drop;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    pair_d       = pair_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    frame_err_d  = frame_err_q;
    restart_d    = restart_q;
    overflow_d   = overflow_q;
    enq_valid    = 1'b0;
    enq_last     = 1'b0;
    enq_word     = '0;
    capture      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_HEADER;
          pix_cnt_d = '0;
        end
      end
      ST_HEADER: begin
        enq_valid = 1'b1;
        enq_word  = {HEADER_MAGIC, frame_cnt_q};
        capture   = data_valid;
        state_d   = ST_PIXELS;
      end
      ST_PIXELS: begin
        if (frame_start) begin
          frame_err_d = 1'b1;
          restart_d   = 1'b1;
          state_d     = ST_TRAILER;
        end else if (pix_cnt_q == PIX_TARGET) begin
          // The last pair word drains this cycle, ahead of the trailer
          state_d = ST_TRAILER;
        end else begin
          capture = data_valid;
        end
      end
      ST_TRAILER: begin
        enq_valid                     = 1'b1;
        enq_last                      = 1'b1;
        enq_word[TAG_LSB +: 8]        = TRAILER_TAG;
        enq_word[ERR_BIT]             = frame_err_q;
        enq_word[CNT_LSB +: CNT_W]    = pix_cnt_q;
        frame_cnt_d                   = frame_cnt_q + 16'd1;
        frame_err_d                   = 1'b0;
        restart_d                     = 1'b0;
        pix_cnt_d                     = '0;
        state_d                       = restart_q ? ST_HEADER : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pixel words only use the enqueue port when no header or trailer needs it
    if (!enq_valid && pend_valid_q) begin
      enq_valid    = 1'b1;
      enq_word     = pend_word_q;
      pend_valid_d = 1'b0;
    end

    if (capture) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
      if (!pix_cnt_q[0]) begin
        pair_d = compressed_data;
      end else begin
        pend_valid_d                         = 1'b1;
        pend_word_d                          = '0;
        pend_word_d[LO_PIX_LSB +: PIX_W]     = pair_q;
        pend_word_d[HI_PIX_LSB +: PIX_W]     = compressed_data;
      end
    end

    drop = enq_valid && fifo_full && !m_tready;
    if (drop) begin
      overflow_d = 1'b1;
      if (state_q != ST_TRAILER) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge ad_fco_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      pair_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      frame_err_q  <= 1'b0;
      restart_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pair_q       <= pair_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      frame_err_q  <= frame_err_d;
      restart_q    <= restart_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ad_fco_clk),
    .rst_i   (reset),
    .push_i  (enq_valid),
    .data_i  ({enq_last, enq_word}),
    .pop_i   (m_tready),
    .data_o  (fifo_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = fifo_rd[WORD_W-1:0];
  assign m_tlast   = fifo_rd[WORD_W];
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_data_frame_packer.sv
// Directed bench for data_frame_packer: full frames, abort, back-pressure overflow,
// mid-frame reset and toggling ready, each checked against hand-derived word sequences.
module tb_data_frame_packer;

  logic        ad_fco_clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        data_valid;
  logic [13:0] compressed_data;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] frame_cnt;
  logic        overflow;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          tog   = 1'b0;
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];

  always #5 ad_fco_clk = ~ad_fco_clk;

  data_frame_packer dut (
    .ad_fco_clk      (ad_fco_clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .data_valid      (data_valid),
    .compressed_data (compressed_data),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .frame_cnt       (frame_cnt),
    .overflow        (overflow)
  );

  // Inputs change 1 time unit after posedge, so the handshake is stable at negedge
  always @(negedge ad_fco_clk) begin
    if (!reset && m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ad_fco_clk);
    #1;
    if (tog) m_tready = ~m_tready;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  function automatic logic [13:0] pix_val(input int k, input bit hi);
    return (hi && (k == 2 || k == 3)) ? 14'h3FFF : 14'(k);
  endfunction

  task automatic exp_pair(input int k, input bit hi);
    exp_q.push_back({1'b0, 2'b00, pix_val(k, hi), 2'b00, pix_val(k - 1, hi)});
  endtask

  task automatic exp_hdr(input logic [15:0] cnt);
    exp_q.push_back({1'b0, 16'hAA55, cnt});
  endtask

  task automatic exp_trl(input logic err, input logic [15:0] n);
    exp_q.push_back({1'b1, 8'hEE, 7'd0, err, n});
  endtask

  // One pixel every 2 cycles; optional latency probe on the first pair
  task automatic send_pixels(input int first, input int last, input bit hi,
                             input bit model, input bit lat);
    for (int k = first; k <= last; k++) begin
      data_valid      = 1'b1;
      compressed_data = pix_val(k, hi);
      tick();
      data_valid = 1'b0;
      if (lat && k == 1) check("lat_c1_tvalid", 64'(m_tvalid), 64'd0);
      tick();
      if (lat && k == 1) begin
        check("lat_c2_tvalid", 64'(m_tvalid), 64'd1);
        check("lat_c2_tdata", 64'(m_tdata), 64'h0001_0000);
      end
      if (model && (k % 2) == 1) exp_pair(k, hi);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 64 && m_tvalid; i++) tick();
    check(tag, 64'(m_tvalid), 64'd0);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; data_valid = 1'b0;
    compressed_data = '0; m_tready = 1'b1;
    repeat (3) @(posedge ad_fco_clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    tick();

    // Full frame, ready always high, pixel k = k
    start_frame();
    exp_hdr(16'd0);
    send_pixels(0, 5183, 1'b0, 1'b1, 1'b1);
    exp_trl(1'b0, 16'h1440);
    repeat (4) tick();
    wait_drain("f0_drain");
    compare("f0");
    check("f0_frame_cnt", 64'(frame_cnt), 64'd1);
    check("f0_overflow", 64'(overflow), 64'd0);

    // Saturated pair, abort after 101 pixels, then a clean frame from the auto header
    start_frame();
    exp_hdr(16'd1);
    send_pixels(0, 100, 1'b1, 1'b1, 1'b0);
    exp_trl(1'b1, 16'h0065);
    start_frame();
    exp_hdr(16'd2);
    send_pixels(0, 5183, 1'b0, 1'b1, 1'b0);
    exp_trl(1'b0, 16'h1440);
    repeat (4) tick();
    wait_drain("f12_drain");
    compare("f12");
    check("f12_frame_cnt", 64'(frame_cnt), 64'd3);
    check("f12_overflow", 64'(overflow), 64'd0);

    // Ready held low for a whole frame: only the first FIFO_DEPTH words survive
    m_tready = 1'b0;
    start_frame();
    send_pixels(0, 5183, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check("f3_overflow", 64'(overflow), 64'd1);
    check("f3_frame_cnt", 64'(frame_cnt), 64'd4);
    check("f3_head_tdata", 64'(m_tdata), 64'hAA55_0003);
    exp_hdr(16'd3);
    exp_pair(1, 1'b0);
    exp_pair(3, 1'b0);
    exp_pair(5, 1'b0);
    m_tready = 1'b1;
    repeat (8) tick();
    wait_drain("f3_drain");
    compare("f3");

    // Reset in the middle of a frame with three words buffered
    m_tready = 1'b0;
    start_frame();
    send_pixels(0, 3, 1'b0, 1'b0, 1'b0);
    check("f5_pre_tvalid", 64'(m_tvalid), 64'd1);
    reset = 1'b1;
    #1;
    check("f5_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("f5_rst_tdata", 64'(m_tdata), 64'd0);
    check("f5_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("f5_rst_overflow", 64'(overflow), 64'd0);
    tick();
    reset = 1'b0;
    m_tready = 1'b1;
    send_pixels(0, 5, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("f5_dv_ignored", 64'(m_tvalid), 64'd0);

    // Fill the FIFO, push and pop together while full, then toggle ready every cycle
    m_tready = 1'b0;
    start_frame();
    exp_hdr(16'd0);
    send_pixels(0, 6, 1'b0, 1'b1, 1'b0);
    data_valid      = 1'b1;
    compressed_data = 14'd7;
    tick();
    data_valid = 1'b0;
    m_tready   = 1'b1;
    tick();
    exp_pair(7, 1'b0);
    tog = 1'b1;
    send_pixels(8, 5183, 1'b0, 1'b1, 1'b0);
    exp_trl(1'b0, 16'h1440);
    repeat (4) tick();
    tog = 1'b0;
    m_tready = 1'b1;
    wait_drain("f6_drain");
    compare("f6");
    check("f6_overflow", 64'(overflow), 64'd0);
    check("f6_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
